// File: rtl/tia_audio_sched.sv
// Register front-end and update scheduler for the two-channel TIA-style audio generator.
// Arbitrates CPU/loader writes into shadow registers and commits all six on each audio tick.
`timescale 1ns/1ps
module tia_audio_sched #(
  parameter int DIV = 114
) (
  input  logic       CLK_SYS,
  input  logic       RESET,
  input  logic       CPU_WE,
  input  logic [2:0] CPU_ADDR,
  input  logic [7:0] CPU_DIN,
  input  logic       LD_VALID,
  output logic       LD_READY,
  input  logic [2:0] LD_ADDR,
  input  logic [7:0] LD_DIN,
  input  logic       HOLD,
  output logic [3:0] AUDC0,
  output logic [3:0] AUDC1,
  output logic [4:0] AUDF0,
  output logic [4:0] AUDF1,
  output logic [3:0] AUDV0,
  output logic [3:0] AUDV1,
  output logic       TICK,
  output logic       DIRTY
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  function automatic logic [3:0] fn_lo4(input logic [7:0] d);
    return d[3:0];
  endfunction

  function automatic logic [4:0] fn_lo5(input logic [7:0] d);
    return d[4:0];
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             commit;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [7:0]       wr_data;

  logic [3:0] sh_audc0_p0, sh_audc1_p0, sh_audv0_p0, sh_audv1_p0;
  logic [4:0] sh_audf0_p0, sh_audf1_p0;

  // CPU wins every collision; the loader simply sees LD_READY low and retries.
  always_comb begin
    LD_READY = ~CPU_WE & ~RESET;
    wr_en    = CPU_WE | (LD_VALID & ~CPU_WE);
    wr_addr  = CPU_WE ? CPU_ADDR : LD_ADDR;
    wr_data  = CPU_WE ? CPU_DIN  : LD_DIN;
    commit   = ~HOLD & (cnt == CNT_LAST);
  end

  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else begin
      if (!HOLD) cnt <= commit ? '0 : cnt + 1'b1;
      TICK <= commit;
    end
  end

  // Stage p0: shadow registers, written by whichever requester won arbitration.
  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      sh_audc0_p0 <= '0;
      sh_audc1_p0 <= '0;
      sh_audf0_p0 <= '0;
      sh_audf1_p0 <= '0;
      sh_audv0_p0 <= '0;
      sh_audv1_p0 <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0:    sh_audc0_p0 <= fn_lo4(wr_data);
        3'd1:    sh_audc1_p0 <= fn_lo4(wr_data);
        3'd2:    sh_audf0_p0 <= fn_lo5(wr_data);
        3'd3:    sh_audf1_p0 <= fn_lo5(wr_data);
        3'd4:    sh_audv0_p0 <= fn_lo4(wr_data);
        3'd5:    sh_audv1_p0 <= fn_lo4(wr_data);
        default: ;
      endcase
    end
  end

  // Stage p1: committed set, loaded atomically from pre-edge shadow values.
  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      AUDC0 <= '0;
      AUDC1 <= '0;
      AUDF0 <= '0;
      AUDF1 <= '0;
      AUDV0 <= '0;
      AUDV1 <= '0;
    end else if (commit) begin
      AUDC0 <= sh_audc0_p0;
      AUDC1 <= sh_audc1_p0;
      AUDF0 <= sh_audf0_p0;
      AUDF1 <= sh_audf1_p0;
      AUDV0 <= sh_audv0_p0;
      AUDV1 <= sh_audv1_p0;
    end
  end

  // A write landing in the commit cycle misses this tick, so it must keep DIRTY set.
  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      DIRTY <= 1'b0;
    end else if (wr_en && (wr_addr <= 3'd5)) begin
      DIRTY <= 1'b1;
    end else if (commit) begin
      DIRTY <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tia_audio_sched.sv
// Bench for tia_audio_sched with DIV=4: per-cycle vector table for handshake/tick/dirty,
// plus a queue of expected committed register sets popped on each TICK.
`timescale 1ns/1ps
module tb_tia_audio_sched;

  logic       CLK_SYS;
  logic       RESET;
  logic       CPU_WE;
  logic [2:0] CPU_ADDR;
  logic [7:0] CPU_DIN;
  logic       LD_VALID;
  logic       LD_READY;
  logic [2:0] LD_ADDR;
  logic [7:0] LD_DIN;
  logic       HOLD;
  logic [3:0] AUDC0, AUDC1, AUDV0, AUDV1;
  logic [4:0] AUDF0, AUDF1;
  logic       TICK;
  logic       DIRTY;

  tia_audio_sched #(.DIV(4)) dut (
    .CLK_SYS (CLK_SYS),
    .RESET   (RESET),
    .CPU_WE  (CPU_WE),
    .CPU_ADDR(CPU_ADDR),
    .CPU_DIN (CPU_DIN),
    .LD_VALID(LD_VALID),
    .LD_READY(LD_READY),
    .LD_ADDR (LD_ADDR),
    .LD_DIN  (LD_DIN),
    .HOLD    (HOLD),
    .AUDC0   (AUDC0),
    .AUDC1   (AUDC1),
    .AUDF0   (AUDF0),
    .AUDF1   (AUDF1),
    .AUDV0   (AUDV0),
    .AUDV1   (AUDV1),
    .TICK    (TICK),
    .DIRTY   (DIRTY)
  );

  initial CLK_SYS = 1'b0;
  always #5 CLK_SYS = ~CLK_SYS;

  typedef struct packed {
    logic       cwe;
    logic [2:0] ca;
    logic [7:0] cd;
    logic       lv;
    logic [2:0] la;
    logic [7:0] ld;
    logic       hold;
    logic       rdy;
    logic       tick;
    logic       dirty;
  } vec_t;

  localparam int NV = 57;
  vec_t tbl [NV];

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  sh [6];
  logic [25:0] sbq [$];
  logic [25:0] cur_exp;

  function automatic vec_t mk(input logic cwe, input logic [2:0] ca, input logic [7:0] cd,
                              input logic lv, input logic [2:0] la, input logic [7:0] ld,
                              input logic hold, input logic rdy, input logic tick,
                              input logic dirty);
    vec_t v;
    v.cwe = cwe; v.ca = ca; v.cd = cd;
    v.lv = lv; v.la = la; v.ld = ld;
    v.hold = hold; v.rdy = rdy; v.tick = tick; v.dirty = dirty;
    return v;
  endfunction

  function automatic vec_t idle(input logic hold, input logic tick, input logic dirty);
    return mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, hold, 1'b1, tick, dirty);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [25:0] model_pack();
    return {sh[0][3:0], sh[1][3:0], sh[2][4:0], sh[3][4:0], sh[4][3:0], sh[5][3:0]};
  endfunction

  function automatic logic [25:0] dut_outs();
    return {AUDC0, AUDC1, AUDF0, AUDF1, AUDV0, AUDV1};
  endfunction

  task automatic model_wr(input logic [2:0] a, input logic [7:0] d);
    if (a == 3'd2 || a == 3'd3) sh[a] = d & 8'h1F;
    else if (a <= 3'd5) sh[a] = d & 8'h0F;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) sh[i] = 8'h00;
    sbq.delete();
    cur_exp = '0;
  endtask

  task automatic run(input vec_t v);
    @(negedge CLK_SYS);
    CPU_WE = v.cwe; CPU_ADDR = v.ca; CPU_DIN = v.cd;
    LD_VALID = v.lv; LD_ADDR = v.la; LD_DIN = v.ld;
    HOLD = v.hold;
    #1;
    chk("ld_ready", LD_READY, v.rdy);
    if (v.tick) sbq.push_back(model_pack());
    if (v.cwe) model_wr(v.ca, v.cd);
    else if (v.lv) model_wr(v.la, v.ld);
    @(posedge CLK_SYS);
    #1;
    chk("tick", TICK, v.tick);
    chk("dirty", DIRTY, v.dirty);
    if (TICK) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL sb_pop: TICK with no expected commit at %0t", $time);
      end else begin
        cur_exp = sbq.pop_front();
      end
    end
    chk("outputs", dut_outs(), cur_exp);
  endtask

  initial begin
    RESET = 1'b0; HOLD = 1'b0;
    CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
    LD_VALID = 1'b0; LD_ADDR = '0; LD_DIN = '0;
    model_reset();

    // idle: ticks after edges 4, 8 (cycles 5, 9)
    for (int i = 0; i < 9; i++) tbl[i] = idle(1'b0, (i == 3 || i == 7), 1'b0);
    tbl[9]  = mk(1, 3'd2, 8'hFF, 0, 3'd0, 8'h00, 0, 0, 0, 1);
    tbl[10] = idle(0, 0, 1);
    tbl[11] = idle(0, 1, 0);
    tbl[12] = mk(1, 3'd0, 8'h0A, 1, 3'd1, 8'h07, 0, 0, 0, 1);
    tbl[13] = mk(0, 3'd0, 8'h00, 1, 3'd1, 8'h07, 0, 1, 0, 1);
    tbl[14] = idle(0, 0, 1);
    tbl[15] = idle(0, 1, 0);
    tbl[16] = idle(0, 0, 0);
    tbl[17] = idle(0, 0, 0);
    tbl[18] = idle(0, 0, 0);
    tbl[19] = mk(1, 3'd5, 8'h03, 0, 3'd0, 8'h00, 0, 0, 1, 1);
    tbl[20] = idle(0, 0, 1);
    tbl[21] = idle(0, 0, 1);
    tbl[22] = idle(0, 0, 1);
    tbl[23] = idle(0, 1, 0);
    tbl[24] = mk(1, 3'd4, 8'h59, 0, 3'd0, 8'h00, 0, 0, 0, 1);
    for (int i = 25; i < 35; i++) tbl[i] = idle(1, 0, 1);
    tbl[29] = mk(0, 3'd0, 8'h00, 1, 3'd3, 8'h35, 1, 1, 0, 1);
    tbl[31] = mk(1, 3'd7, 8'hFF, 0, 3'd0, 8'h00, 1, 0, 0, 1);
    tbl[35] = idle(0, 0, 1);
    tbl[36] = idle(0, 0, 1);
    tbl[37] = idle(0, 1, 0);
    tbl[38] = idle(0, 0, 0);
    tbl[39] = idle(0, 0, 0);
    tbl[40] = mk(1, 3'd6, 8'hFF, 0, 3'd0, 8'h00, 0, 0, 0, 0);
    tbl[41] = mk(0, 3'd0, 8'h00, 1, 3'd4, 8'h0F, 1, 1, 0, 1);
    tbl[42] = idle(0, 1, 0);
    tbl[43] = mk(0, 3'd0, 8'h00, 1, 3'd7, 8'hAA, 0, 1, 0, 0);
    tbl[44] = mk(1, 3'd1, 8'hF3, 1, 3'd0, 8'h05, 0, 0, 0, 1);
    tbl[45] = mk(0, 3'd0, 8'h00, 1, 3'd0, 8'h05, 0, 1, 0, 1);
    tbl[46] = idle(0, 1, 0);
    tbl[47] = mk(1, 3'd2, 8'h01, 0, 3'd0, 8'h00, 0, 0, 0, 1);
    tbl[48] = mk(1, 3'd2, 8'h02, 0, 3'd0, 8'h00, 0, 0, 0, 1);
    tbl[49] = mk(0, 3'd0, 8'h00, 1, 3'd2, 8'h1E, 0, 1, 0, 1);
    tbl[50] = idle(0, 1, 0);
    for (int i = 0; i < 6; i++) tbl[51 + i] = mk(1, 3'(i), 8'hFF, 0, 3'd0, 8'h00, 1, 0, 0, 1);

    // reset state, with a pending loader request to show LD_READY gated by RESET
    #1 RESET = 1'b1;
    LD_VALID = 1'b1;
    repeat (2) @(posedge CLK_SYS);
    #1;
    chk("rst_ld_ready", LD_READY, 0);
    chk("rst_tick", TICK, 0);
    chk("rst_dirty", DIRTY, 0);
    chk("rst_outputs", dut_outs(), 0);
    LD_VALID = 1'b0;
    @(posedge CLK_SYS);
    #2 RESET = 1'b0;

    for (int i = 0; i < NV; i++) run(tbl[i]);

    // asynchronous reset mid-interval with every shadow register pending
    CPU_WE = 1'b0; LD_VALID = 1'b1; HOLD = 1'b0;
    #1 RESET = 1'b1;
    #1;
    chk("midrst_outputs", dut_outs(), 0);
    chk("midrst_dirty", DIRTY, 0);
    chk("midrst_tick", TICK, 0);
    chk("midrst_ld_ready", LD_READY, 0);
    LD_VALID = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK_SYS);
    #2 RESET = 1'b0;
    for (int i = 0; i < 4; i++) run(idle(1'b0, (i == 3), 1'b0));

    chk("sb_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tia_audio_sched.md
# tia_audio_sched

Register front-end and update scheduler for the two-channel TIA-style audio generator. Accepts AUDC/AUDF/AUDV writes from two requesters (CPU bus, save-state/debug loader), arbitrates them into shadow registers, and commits all six channel registers atomically on an internally generated audio tick. The tick also serves as the audio clock enable for the generator, so channel parameters never change mid-sample.

## Interface
Parameters:
- DIV, 114: system clocks per audio tick (≈31.4 kHz at 3.58 MHz); legal range 2..1023.

Ports:
- CLK_SYS  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CPU_WE  in  1  CPU write strobe, one cycle per write; always accepted.
- CPU_ADDR  in  3  register select: 0 AUDC0, 1 AUDC1, 2 AUDF0, 3 AUDF1, 4 AUDV0, 5 AUDV1; 6,7 ignored.
- CPU_DIN  in  8  CPU write data.
- LD_VALID  in  1  loader write request.
- LD_READY  out  1  loader write accepted this cycle when LD_VALID & LD_READY.
- LD_ADDR  in  3  loader register select, same map as CPU_ADDR.
- LD_DIN  in  8  loader write data.
- HOLD  in  1  pause: freezes prescaler and suppresses commits.
- AUDC0, AUDC1  out  4  committed control registers.
- AUDF0, AUDF1  out  5  committed frequency registers.
- AUDV0, AUDV1  out  4  committed volume registers.
- TICK  out  1  one-cycle audio clock enable, coincident with newly committed values.
- DIRTY  out  1  shadow differs (by write history) from committed set.

## Operation
- Arbitration: CPU has fixed priority. LD_READY = ~CPU_WE & ~RESET (combinational). Loader write happens only on cycles with LD_VALID & LD_READY; loader must hold LD_VALID/LD_ADDR/LD_DIN stable until accepted.
- Accepted write updates one shadow register with low bits of data: AUDC/AUDV take DIN[3:0], AUDF takes DIN[4:0]; upper bits discarded. Addresses 6,7: write accepted (handshake completes) but no register changes and DIRTY unaffected.
- Prescaler: counter cnt 0..DIV-1. When HOLD=0, cnt increments; at cnt==DIV-1 it wraps to 0 and a commit occurs. When HOLD=1, cnt holds value, no commit; writes still land in shadow.
- Commit: all six outputs <= shadow values as they stood before that cycle's edge. A write accepted in the commit cycle lands in shadow and is committed at the next tick.
- DIRTY: set on any accepted write to address 0..5; cleared on commit; if a write to 0..5 is accepted in the commit cycle, DIRTY stays/becomes 1.
- Multiple writes to the same register between ticks: last accepted value wins.

## Timing
- Reset (async assert): cnt=0, all shadow and committed registers 0, TICK=0, DIRTY=0, LD_READY=0.
- After reset release, first commit edge at end of cycle with cnt==DIV-1, i.e. DIV cycles after release; TICK high the following cycle with new outputs visible the same cycle.
- TICK period exactly DIV cycles while HOLD=0; TICK width exactly 1 cycle. HOLD asserted during a cycle with cnt==DIV-1 suppresses that commit; on release, counting resumes from held cnt.
- Write-to-output latency: 1 to DIV+1 cycles depending on phase; never partial (all six update on the same edge).
- Reset mid-operation: pending shadow writes discarded, outputs return to 0 immediately (async), TICK deasserted.
- CPU_WE and LD_VALID same cycle: CPU write taken, LD_READY=0, loader retries next cycle.

## Test plan
- Reset then idle, DIV=4: TICK pulses at cycles 5, 9, 13 after release; all outputs 0, DIRTY 0.
- CPU writes AUDF0=0xFF at cnt=1: AUDF0 stays 0 until next TICK, then 0x1F; DIRTY 1 from write to commit, then 0.
- CPU_WE and LD_VALID asserted together (CPU addr 0 data 0x0A, loader addr 1 data 0x07): LD_READY=0 that cycle, 1 next; after tick AUDC0=0xA, AUDC1=0x7.
- Write AUDV1=0x3 in the commit cycle: not committed this tick, DIRTY remains 1, AUDV1=0x3 after the following tick.
- HOLD=1 for 10 cycles with DIV=4 and a pending write: no TICK, outputs unchanged, DIRTY 1; after HOLD=0, commit at remaining count.
- Assert RESET mid-interval after writes to all six registers: outputs and DIRTY immediately 0, first subsequent TICK after DIV cycles shows all zeros.
